// File: rtl/data_memory_pkg.sv
// ---------------------------------------------------------------------------
// data_memory_pkg
// Shared constants for the data memory slice: array depth, address width and
// the default data word width. Imported by data_memory and data_memory_array.
// ---------------------------------------------------------------------------
package data_memory_pkg;

    localparam int DMEM_DEPTH         = 256;
    localparam int DMEM_ADDR_W        = 8;
    localparam int DMEM_DEFAULT_WIDTH = 32;

endpackage : data_memory_pkg

// File: rtl/data_memory_array.sv
// ---------------------------------------------------------------------------
// data_memory_array
// 256-word storage array with one synchronous write port, an asynchronous
// (combinational) read port and a synchronous clear of every word on reset.
//
// Ports:
//   clk_i    rising-edge clock
//   reset_i  synchronous active-high reset, clears all words, beats a write
//   we_i     write enable, stores wdata_i at addr_i on the next edge
//   addr_i   word address
//   wdata_i  write data
//   rdata_o  word currently held at addr_i (pre-edge contents)
// ---------------------------------------------------------------------------
module data_memory_array
    import data_memory_pkg::*;
#(
    parameter int Width = DMEM_DEFAULT_WIDTH
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   we_i,
    input  logic [DMEM_ADDR_W-1:0] addr_i,
    input  logic [Width-1:0]       wdata_i,
    output logic [Width-1:0]       rdata_o
);

    logic [Width-1:0] mem_q [DMEM_DEPTH];

    // Reset is checked first so a write presented on a reset edge is dropped.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int i = 0; i < DMEM_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule : data_memory_array

// File: rtl/data_memory.sv
// ---------------------------------------------------------------------------
// data_memory
// Word-addressed data memory: 256 words of Width bits (legal Width 8..64).
// Wraps data_memory_array with read-enable gating and an optional output
// register.
//
// Configuration macro: DMEM_READ_REG_EN
//   undefined : ReadData = MemRead ? mem[Addr] : 0, combinationally, so a
//               write becomes visible right after its edge.
//   defined   : ReadData is registered; on an edge with MemRead=1 it loads
//               the pre-write word at Addr, otherwise it holds. Cleared on
//               reset. One cycle of read latency.
//
// Ports:
//   clk       rising-edge clock
//   reset     synchronous active-high reset, clears the whole array
//   MemWrite  write enable
//   MemRead   read enable
//   Addr      word address 0..255
//   WrData    write data
//   ReadData  read data
// ---------------------------------------------------------------------------
module data_memory
    import data_memory_pkg::*;
#(
    parameter int Width = DMEM_DEFAULT_WIDTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   MemWrite,
    input  logic                   MemRead,
    input  logic [DMEM_ADDR_W-1:0] Addr,
    input  logic [Width-1:0]       WrData,
    output logic [Width-1:0]       ReadData
);

    logic [Width-1:0] arrayData;

    data_memory_array #(
        .Width(Width)
    ) u_array (
        .clk_i   (clk),
        .reset_i (reset),
        .we_i    (MemWrite),
        .addr_i  (Addr),
        .wdata_i (WrData),
        .rdata_o (arrayData)
    );

`ifdef DMEM_READ_REG_EN
    logic [Width-1:0] readData_q;
    logic [Width-1:0] readData_d;

    // arrayData reflects the contents before this edge's write, which gives
    // read-old-data behaviour when reading and writing the same word.
    always_comb begin
        readData_d = readData_q;
        if (MemRead) begin
            readData_d = arrayData;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            readData_q <= '0;
        end else begin
            readData_q <= readData_d;
        end
    end

    assign ReadData = readData_q;
`else
    assign ReadData = MemRead ? arrayData : '0;
`endif

endmodule : data_memory

// File: tb/tb_data_memory.sv
// ---------------------------------------------------------------------------
// tb_data_memory
// Self-checking bench for data_memory (Width = 32). Expected read values come
// from a bench-side memory model and pass through a scoreboard queue.
// Adapts its sampling points when DMEM_READ_REG_EN is defined.
// ---------------------------------------------------------------------------
module tb_data_memory;
    import data_memory_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         MemWrite;
    logic         MemRead;
    logic [7:0]   Addr;
    logic [W-1:0] WrData;
    logic [W-1:0] ReadData;

    logic [W-1:0] model [DMEM_DEPTH];
    logic [W-1:0] expQ [$];
    logic [W-1:0] lastRead;
    int           checks   = 0;
    int           failures = 0;

    data_memory #(
        .Width(W)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .MemWrite (MemWrite),
        .MemRead  (MemRead),
        .Addr     (Addr),
        .WrData   (WrData),
        .ReadData (ReadData)
    );

    // Free-running 10 ns clock; inputs change on the falling edge.
    always #5 clk = ~clk;

    task automatic clearModel();
        foreach (model[i]) model[i] = '0;
        lastRead = '0;
    endtask

    task automatic doReset(input logic wantWrite, input logic [7:0] a, input logic [W-1:0] d);
        @(negedge clk);
        reset    = 1'b1;
        MemWrite = wantWrite;
        MemRead  = 1'b0;
        Addr     = a;
        WrData   = d;
        @(posedge clk);
        #1;
        reset    = 1'b0;
        MemWrite = 1'b0;
        clearModel();
    endtask

    task automatic doWrite(input logic [7:0] a, input logic [W-1:0] d);
        @(negedge clk);
        MemWrite = 1'b1;
        MemRead  = 1'b0;
        Addr     = a;
        WrData   = d;
        @(posedge clk);
        model[a] = d;
        #1;
        MemWrite = 1'b0;
    endtask

    // Drives a read and pushes its expected result; returns once ReadData is valid.
    task automatic doRead(input logic [7:0] a);
        @(negedge clk);
        MemWrite = 1'b0;
        MemRead  = 1'b1;
        Addr     = a;
        expQ.push_back(model[a]);
        lastRead = model[a];
`ifdef DMEM_READ_REG_EN
        @(posedge clk);
`endif
        #1;
    endtask

    task automatic test_reset();
        logic [W-1:0] exp;
        doReset(1'b0, 8'h00, '0);
        checks++;
        if (ReadData !== 32'h0) begin
            failures++;
            $display("[TB] FAIL reset_out: got %h expected %h", ReadData, 32'h0);
        end
        for (int i = 0; i < 2; i++) begin
            doRead(i == 0 ? 8'h00 : 8'hFF);
            exp = expQ.pop_front();
            checks++;
            if (ReadData !== exp || ReadData !== 32'h0) begin
                failures++;
                $display("[TB] FAIL reset_read%0d: got %h expected %h", i, ReadData, 32'h0);
            end
        end
    endtask

    task automatic test_write_read();
        logic [W-1:0] old;
        logic [W-1:0] exp;
        @(negedge clk);
        MemWrite = 1'b1;
        MemRead  = 1'b1;
        Addr     = 8'h00;
        WrData   = 32'hAAAAAAAA;
        old      = model[8'h00];
`ifdef DMEM_READ_REG_EN
        expQ.push_back(lastRead);
`else
        expQ.push_back(old);
`endif
        #1;
        exp = expQ.pop_front();
        checks++;
        if (ReadData !== exp) begin
            failures++;
            $display("[TB] FAIL rdw_before_edge: got %h expected %h", ReadData, exp);
        end
        @(posedge clk);
        model[8'h00] = 32'hAAAAAAAA;
`ifdef DMEM_READ_REG_EN
        expQ.push_back(old);
`else
        expQ.push_back(model[8'h00]);
`endif
        #1;
        MemWrite = 1'b0;
        exp = expQ.pop_front();
        checks++;
        if (ReadData !== exp) begin
            failures++;
            $display("[TB] FAIL rdw_after_edge: got %h expected %h", ReadData, exp);
        end
        doRead(8'h00);
        exp = expQ.pop_front();
        checks++;
        if (ReadData !== exp || ReadData !== 32'hAAAAAAAA) begin
            failures++;
            $display("[TB] FAIL write_read: got %h expected %h", ReadData, 32'hAAAAAAAA);
        end
    endtask

    task automatic test_independent();
        logic [7:0]   addrs [3];
        logic [W-1:0] exp;
        addrs = '{8'h05, 8'hFF, 8'h06};
        doWrite(8'h05, 32'h12345678);
        doWrite(8'hFF, 32'hDEADBEEF);
        foreach (addrs[i]) begin
            doRead(addrs[i]);
            exp = expQ.pop_front();
            checks++;
            if (ReadData !== exp) begin
                failures++;
                $display("[TB] FAIL indep_addr_%h: got %h expected %h", addrs[i], ReadData, exp);
            end
        end
    endtask

    task automatic test_read_gating();
        logic [W-1:0] exp;
        doRead(8'h05);
        exp = expQ.pop_front();
        checks++;
        if (ReadData !== exp) begin
            failures++;
            $display("[TB] FAIL gating_pre: got %h expected %h", ReadData, exp);
        end
        @(negedge clk);
        MemRead = 1'b0;
        Addr    = 8'h05;
`ifdef DMEM_READ_REG_EN
        expQ.push_back(lastRead);
        @(posedge clk);
`else
        expQ.push_back('0);
`endif
        #1;
        exp = expQ.pop_front();
        checks++;
        if (ReadData !== exp) begin
            failures++;
            $display("[TB] FAIL gating_off: got %h expected %h", ReadData, exp);
        end
    endtask

    task automatic test_write_disabled();
        logic [W-1:0] exp;
        @(negedge clk);
        MemWrite = 1'b0;
        MemRead  = 1'b0;
        Addr     = 8'h05;
        WrData   = 32'hFFFFFFFF;
        repeat (3) @(posedge clk);
        doRead(8'h05);
        exp = expQ.pop_front();
        checks++;
        if (ReadData !== exp || ReadData !== 32'h12345678) begin
            failures++;
            $display("[TB] FAIL write_disabled: got %h expected %h", ReadData, 32'h12345678);
        end
    endtask

    task automatic test_reset_priority();
        logic [7:0]   addrs [3];
        logic [W-1:0] exp;
        addrs = '{8'h10, 8'h05, 8'hFF};
        doReset(1'b1, 8'h10, 32'h55555555);
        foreach (addrs[i]) begin
            doRead(addrs[i]);
            exp = expQ.pop_front();
            checks++;
            if (ReadData !== exp || ReadData !== 32'h0) begin
                failures++;
                $display("[TB] FAIL reset_prio_%h: got %h expected %h", addrs[i], ReadData, 32'h0);
            end
        end
    endtask

    // Random mixed traffic over a small address window to force collisions.
    task automatic test_back_to_back();
        logic [7:0]   a;
        logic         we;
        logic [W-1:0] d;
        logic [W-1:0] old;
        logic [W-1:0] exp;
        for (int n = 0; n < 40; n++) begin
            a  = 8'($urandom_range(0, 15));
            we = 1'($urandom_range(0, 1));
            d  = $urandom;
            @(negedge clk);
            MemWrite = we;
            MemRead  = 1'b1;
            Addr     = a;
            WrData   = d;
            old      = model[a];
`ifdef DMEM_READ_REG_EN
            expQ.push_back(lastRead);
`else
            expQ.push_back(old);
`endif
            #1;
            exp = expQ.pop_front();
            checks++;
            if (ReadData !== exp) begin
                failures++;
                $display("[TB] FAIL b2b_pre_%0d: got %h expected %h", n, ReadData, exp);
            end
            @(posedge clk);
            if (we) model[a] = d;
`ifdef DMEM_READ_REG_EN
            expQ.push_back(old);
            lastRead = old;
`else
            expQ.push_back(model[a]);
`endif
            #1;
            exp = expQ.pop_front();
            checks++;
            if (ReadData !== exp) begin
                failures++;
                $display("[TB] FAIL b2b_post_%0d: got %h expected %h", n, ReadData, exp);
            end
        end
        @(negedge clk);
        MemWrite = 1'b0;
    endtask

    initial begin
        reset    = 1'b0;
        MemWrite = 1'b0;
        MemRead  = 1'b0;
        Addr     = '0;
        WrData   = '0;
        clearModel();
        test_reset();
        test_write_read();
        test_independent();
        test_read_gating();
        test_write_disabled();
        test_reset_priority();
        test_independent();
        test_back_to_back();
        checks++;
        if (expQ.size() != 0) begin
            failures++;
            $display("[TB] FAIL scoreboard_drain: got %0d expected %0d", expQ.size(), 0);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Guard against a stalled run.
    initial begin
        #200000;
        $display("[TB] FAIL timeout: got %0d expected %0d", 0, 1);
        $fatal(1, "[TB] timeout");
    end

endmodule : tb_data_memory
